mem_bus_arbiter: RTL and testbench

Sequences the CPU's single memory port between two requesters: instruction fetch (port F, driven by the control unit during fetch states) and data load/store (port D, driven during execute states). It latches one request at a time, drives the memory address/data/enable lines until the memory signals completion, then returns read data and a one-cycle acknowledge to the winner. It sits between the control unit/MAR-MDR datapath and the memory.

---
 rtl/mem_bus_arbiter.sv | 84 ++++++++
 tb/tb_mem_bus_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates the memory port between fetch (F) and data (D) requesters; ports: clock, reset (active-low), F/D request+ack, err/busy, mem_* bus
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 15,
  parameter int MAX_CONSEC = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic owner_d, we_r, f_el, d_el, grant_f, grant_d, done;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [7:0] tcount;
  logic [3:0] consec;
  assign f_el = f_req & ~f_ack;
  assign d_el = d_req & ~d_ack;
  assign grant_f = (state == IDLE) & f_el & (~d_el | (consec == 4'(MAX_CONSEC)));
  assign grant_d = (state == IDLE) & d_el & ~grant_f;
  assign done = (state == BUSY) & (mem_ready | (tcount == 8'(TIMEOUT - 1)));
  assign busy = state == BUSY;
  assign mem_en = busy;
  assign mem_we = busy & we_r;
  assign mem_addr = addr_r;
  assign mem_wdata = wdata_r;
  always_comb begin
    state_nx = state;
    if (grant_f | grant_d) state_nx = BUSY;
    if (done) state_nx = IDLE;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner_d <= 1'b0;
      we_r <= 1'b0;
      addr_r <= '0;
      wdata_r <= '0;
      tcount <= '0;
      consec <= '0;
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      err <= 1'b0;
      f_rdata <= '0;
      d_rdata <= '0;
    end else begin
      state <= state_nx;
      f_ack <= done & ~owner_d;
      d_ack <= done & owner_d;
      err <= done & ~mem_ready;
      if (grant_f | grant_d) begin
        owner_d <= grant_d;
        addr_r <= grant_f ? f_addr : d_addr;
        we_r <= grant_d & d_we;
        wdata_r <= grant_f ? '0 : d_wdata;
        tcount <= '0;
        consec <= (grant_f | ~f_el) ? 4'd0 : (consec == 4'(MAX_CONSEC)) ? consec : consec + 4'd1;
      end else if (state == BUSY) begin
        tcount <= tcount + 8'd1;
      end
      if (done & ~owner_d) f_rdata <= mem_ready ? mem_rdata : '0;
      if (done & owner_d) d_rdata <= (mem_ready & ~we_r) ? mem_rdata : '0;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: random and directed stimulus checked against a transaction-level model of the arbiter
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;
  localparam int MC = 4;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic f_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [AW-1:0] f_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic f_ack, d_ack, err, busy, mem_en, mem_we;
  logic [DW-1:0] f_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  always #5 clock = ~clock;
  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .MAX_CONSEC(MC)) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .err(err), .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );
  int n_tests = 0;
  int n_fail = 0;
  bit m_busy, m_dwon, m_we, m_tout, m_fack, m_dack, m_err;
  logic [31:0] m_addr, m_wdata, m_rd, m_frdata, m_drdata;
  int m_remain, m_consec;
  int force_wait = -1;
  logic [31:0] force_rd = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    {m_busy, m_dwon, m_we, m_tout, m_fack, m_dack, m_err} = '0;
    {m_addr, m_wdata, m_rd, m_frdata, m_drdata} = '0;
    m_remain = 0;
    m_consec = 0;
  endtask
  // One access lasts min(wait+1, TO) busy cycles; it times out when the memory would need more than TO.
  task automatic model_advance();
    bit nf, nd, ne, fe, de, gf;
    int w;
    nf = 0; nd = 0; ne = 0;
    if (m_busy) begin
      if (m_remain == 1) begin
        m_busy = 0;
        ne = m_tout;
        if (m_dwon) begin
          nd = 1;
          m_drdata = (m_tout || m_we) ? 32'h0 : m_rd;
        end else begin
          nf = 1;
          m_frdata = m_tout ? 32'h0 : m_rd;
        end
      end else m_remain--;
    end else begin
      fe = f_req && !m_fack;
      de = d_req && !m_dack;
      if (fe || de) begin
        gf = fe && (!de || m_consec == MC);
        m_consec = (gf || !fe) ? 0 : (m_consec == MC ? MC : m_consec + 1);
        m_dwon = !gf;
        m_addr = gf ? f_addr : d_addr;
        m_we = !gf && d_we;
        m_wdata = d_wdata;
        w = force_wait >= 0 ? force_wait : int'($urandom_range(0, TO + 1));
        m_rd = force_wait >= 0 ? force_rd : $urandom;
        m_tout = (w + 1) > TO;
        m_remain = m_tout ? TO : w + 1;
        m_busy = 1;
      end
    end
    m_fack = nf;
    m_dack = nd;
    m_err = ne;
  endtask
  task automatic check_all();
    check("busy", busy, m_busy);
    check("mem_en", mem_en, m_busy);
    check("f_ack", f_ack, m_fack);
    check("d_ack", d_ack, m_dack);
    check("err", err, m_err);
    check("f_rdata", f_rdata, m_frdata);
    check("d_rdata", d_rdata, m_drdata);
    check("ack_excl", f_ack & d_ack, 0);
    if (m_busy) begin
      check("mem_addr", mem_addr, m_addr);
      check("mem_we", mem_we, m_we);
      if (m_we) check("mem_wdata", mem_wdata, m_wdata);
    end
  endtask
  task automatic tick();
    mem_ready = m_busy && m_remain == 1 && !m_tout;
    mem_rdata = mem_ready ? m_rd : $urandom;
    model_advance();
    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask
  task automatic single(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int w, input logic [31:0] rd);
    int lat;
    bit got;
    lat = 0;
    got = 0;
    force_wait = w;
    force_rd = rd;
    if (is_d) begin
      d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1; f_addr = addr;
    end
    for (int i = 0; i < TO + 6 && !got; i++) begin
      tick();
      lat++;
      got = is_d ? d_ack : f_ack;
    end
    force_wait = -1;
    check("latency", got ? lat : -1, (w + 1 > TO) ? TO + 1 : w + 2);
    f_req = 0;
    d_req = 0;
    tick();
  endtask
  initial begin
    bit rst_done;
    bit got;
    rst_done = 0;
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_acks", {f_ack, d_ack, err}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_we", mem_we, 0);
    reset = 1;
    tick();
    single(0, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    check("fetch_rdata", f_rdata, 32'hDEADBEEF);
    single(1, 1, 32'h40, 32'h12345678, 3, 32'hCAFEF00D);
    check("store_rdata", d_rdata, 0);
    single(1, 0, 32'h44, 32'h0, TO + 3, 32'h5A5A5A5A);
    single(1, 0, 32'h48, 32'h0, TO - 1, 32'hA5A5A5A5);
    check("late_ready_rdata", d_rdata, 32'hA5A5A5A5);
    d_req = 1; d_we = 0; d_addr = 32'h80; force_wait = 1; force_rd = 32'h11111111;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      got = d_ack;
    end
    check("ignore_ack_seen", got, 1);
    f_req = 1; f_addr = 32'h300; force_wait = 0; force_rd = 32'h22222222;
    tick();
    check("ignore_grant_busy", busy, 1);
    check("ignore_grant_addr", mem_addr, 32'h300);
    d_req = 0;
    tick();
    check("ignore_f_ack", f_ack, 1);
    f_req = 0; force_wait = -1;
    tick();
    check("ignore_no_regrant", busy, 0);
    for (int c = 0; c < 4000; c++) begin
      if (m_fack) f_req = 1'($urandom_range(0, 1));
      else if (!f_req) f_req = ($urandom_range(0, 2) == 0);
      if (m_dack) d_req = 1'($urandom_range(0, 1));
      else if (!d_req) d_req = ($urandom_range(0, 2) == 0);
      f_addr = $urandom;
      d_addr = $urandom;
      d_wdata = $urandom;
      d_we = 1'($urandom_range(0, 1));
      if (c >= 2000 && !rst_done && m_busy) begin
        rst_done = 1;
        f_req = 0; d_req = 0; mem_ready = 0;
        #2 reset = 0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_mem_en", mem_en, 0);
        check("arst_acks", {f_ack, d_ack, err}, 0);
        check("arst_rdata", f_rdata | d_rdata, 0);
        check("arst_mem_addr", mem_addr, 0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1;
        repeat (3) tick();
      end
      tick();
    end
    check("arst_reached", rst_done, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
